// File: rtl/rv16r.sv
// rv16r: single-cycle 16-bit load/store core with internal ROM/RAM.
// Optional RV16R_HALT_EN makes opcode 0xF freeze the PC until reset.

module rv16r_irom (
  input  logic [9:0]  addr,
  output logic [15:0] data
);

  logic [15:0] ram [0:1023];

  assign data = ram[addr];

endmodule

module rv16r (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  output logic [15:0] printRegOneData,
  output logic [15:0] printRegTwoData,
  output logic [15:0] printRegThreeData
);

  logic [9:0]  pc_q, pc_d;
  logic [9:0]  pc_inc;
  logic [15:0] rf_q [0:15];
  logic [15:0] dmem_q [0:255];
  logic [15:0] instr;
  logic [3:0]  op, rd, rs1, rs2;
  logic [15:0] rd_v, rs1_v, rs2_v;
  logic [9:0]  sx4;
  logic [15:0] sx8;
  logic [15:0] alu_y, wb_v, ld_v;
  logic [7:0]  maddr;
  logic        rf_wen, dm_wen;
  logic        rf_wr, dm_wr;

  rv16r_irom Instructions (
    .addr (pc_q),
    .data (instr)
  );

  assign op  = instr[15:12];
  assign rd  = instr[11:8];
  assign rs1 = instr[7:4];
  assign rs2 = instr[3:0];

  assign rd_v  = (rd  == 4'd0) ? 16'h0000 : rf_q[rd];
  assign rs1_v = (rs1 == 4'd0) ? 16'h0000 : rf_q[rs1];
  assign rs2_v = (rs2 == 4'd0) ? 16'h0000 : rf_q[rs2];

  assign sx4    = {{6{instr[3]}}, instr[3:0]};
  assign sx8    = {{8{instr[7]}}, instr[7:0]};
  assign maddr  = rs1_v[7:0] + sx4[7:0];
  assign ld_v   = dmem_q[maddr];
  assign pc_inc = pc_q + 10'd1;

  // Register-register ALU for opcodes 0x0-0x7
  always_comb begin
    alu_y = 16'h0000;
    unique case (op[2:0])
      3'd0: alu_y = rs1_v + rs2_v;
      3'd1: alu_y = rs1_v - rs2_v;
      3'd2: alu_y = rs1_v & rs2_v;
      3'd3: alu_y = rs1_v | rs2_v;
      3'd4: alu_y = rs1_v ^ rs2_v;
      3'd5: alu_y = {15'd0, $signed(rs1_v) < $signed(rs2_v)};
      3'd6: alu_y = rs1_v << rs2_v[3:0];
      3'd7: alu_y = rs1_v >> rs2_v[3:0];
    endcase
  end

  // Decode: next PC, write-back value and write requests
  always_comb begin
    pc_d   = pc_inc;
    wb_v   = alu_y;
    rf_wen = 1'b0;
    dm_wen = 1'b0;
    if (!op[3]) begin
      rf_wen = 1'b1;
    end else begin
      unique case (op[2:0])
        3'd0: begin
          wb_v   = rd_v + sx8;
          rf_wen = 1'b1;
        end
        3'd1: begin
          wb_v   = {instr[7:0], 8'h00};
          rf_wen = 1'b1;
        end
        3'd2: begin
          wb_v   = ld_v;
          rf_wen = 1'b1;
        end
        3'd3: dm_wen = 1'b1;
        3'd4: begin
          if (rd_v == rs1_v) pc_d = pc_q + sx4;
        end
        3'd5: begin
          if (rd_v != rs1_v) pc_d = pc_q + sx4;
        end
        3'd6: begin
          wb_v   = {6'd0, pc_inc};
          rf_wen = 1'b1;
          pc_d   = pc_q + sx8[9:0];
        end
        3'd7: begin
`ifdef RV16R_HALT_EN
          pc_d = pc_q;
`else
          pc_d = pc_inc;
`endif
        end
      endcase
    end
  end

  // Reset and the global enable override every write request
  assign rf_wr = rf_wen & we & rst & (rd != 4'd0);
  assign dm_wr = dm_wen & we & rst;

  // Program counter
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= 10'd0;
    else      pc_q <= pc_d;
  end

  // Register file, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0000;
    end else if (rf_wr) begin
      rf_q[rd] <= wb_v;
    end
  end

  // Data RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (dm_wr) dmem_q[maddr] <= rd_v;
  end

  assign printRegOneData   = rf_q[15];
  assign printRegTwoData   = rf_q[14];
  assign printRegThreeData = rf_q[13];

endmodule

// File: tb/tb_rv16r.sv
// tb_rv16r: program-trace vectors plus loop, halt, reset and wrap sequences.
// Expected register/PC values are hand-derived constants.

module tb_rv16r;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b1;
  logic [15:0] r15, r14, r13;

  rv16r dut (
    .clk               (clk),
    .rst               (rst),
    .we                (we),
    .printRegOneData   (r15),
    .printRegTwoData   (r14),
    .printRegThreeData (r13)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic        we;
    logic [15:0] r15;
    logic [15:0] r14;
    logic [15:0] r13;
  } vec_t;

  typedef struct {
    logic [15:0] r15;
    logic [15:0] r14;
    logic [15:0] r13;
    logic [9:0]  pc;
  } exp_t;

  localparam int NV = 29;
  vec_t vt [NV];
  exp_t sbq [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [15:0] ins, input logic w,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c);
    vt[i] = '{ins, w, a, b, c};
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) dut.Instructions.ram[i] = 16'h0000;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string nm, input logic [9:0] exp);
    check(nm, {6'd0, dut.pc_q}, {6'd0, exp});
  endtask

  initial begin
    exp_t e;
    int   c;

    setv( 0, 16'h8F05, 1, 16'h0005, 16'h0000, 16'h0000);
    setv( 1, 16'h8EFD, 1, 16'h0005, 16'hFFFD, 16'h0000);
    setv( 2, 16'h9D12, 1, 16'h0005, 16'hFFFD, 16'h1200);
    setv( 3, 16'h8107, 1, 16'h0005, 16'hFFFD, 16'h1200);
    setv( 4, 16'h8209, 1, 16'h0005, 16'hFFFD, 16'h1200);
    setv( 5, 16'h1F12, 1, 16'hFFFE, 16'hFFFD, 16'h1200);
    setv( 6, 16'h5E12, 1, 16'hFFFE, 16'h0001, 16'h1200);
    setv( 7, 16'h4D12, 1, 16'hFFFE, 16'h0001, 16'h000E);
    setv( 8, 16'h8123, 1, 16'hFFFE, 16'h0001, 16'h000E);
    setv( 9, 16'hB103, 1, 16'hFFFE, 16'h0001, 16'h000E);
    setv(10, 16'hAF03, 1, 16'h002A, 16'h0001, 16'h000E);
    setv(11, 16'h81DD, 1, 16'h002A, 16'h0001, 16'h000E);
    setv(12, 16'hB103, 0, 16'h002A, 16'h0001, 16'h000E);
    setv(13, 16'h8F01, 0, 16'h002A, 16'h0001, 16'h000E);
    setv(14, 16'h8F01, 1, 16'h002B, 16'h0001, 16'h000E);
    setv(15, 16'hAF03, 1, 16'h002A, 16'h0001, 16'h000E);
    setv(16, 16'hAD1C, 1, 16'h002A, 16'h0001, 16'h002A);
    setv(17, 16'h81FC, 1, 16'h002A, 16'h0001, 16'h002A);
    setv(18, 16'h0011, 1, 16'h002A, 16'h0001, 16'h002A);
    setv(19, 16'h0F00, 1, 16'h0000, 16'h0001, 16'h002A);
    setv(20, 16'h6E12, 1, 16'h0000, 16'h0600, 16'h002A);
    setv(21, 16'h7DE1, 1, 16'h0000, 16'h0600, 16'h00C0);
    setv(22, 16'h9E80, 1, 16'h0000, 16'h8000, 16'h00C0);
    setv(23, 16'h7FE1, 1, 16'h1000, 16'h8000, 16'h00C0);
    setv(24, 16'h5EE1, 1, 16'h1000, 16'h0001, 16'h00C0);
    setv(25, 16'h2D12, 1, 16'h1000, 16'h0001, 16'h0001);
    setv(26, 16'h3F12, 1, 16'h000B, 16'h0001, 16'h0001);
    setv(27, 16'h0E12, 1, 16'h000B, 16'h000C, 16'h0001);
    setv(28, 16'h5D21, 1, 16'h000B, 16'h000C, 16'h0000);

    clear_rom();
    for (int i = 0; i < NV; i++) dut.Instructions.ram[i] = vt[i].ins;

    // Reset state
    rst = 1'b0;
    we  = 1'b1;
    edge1();
    check("rst_r15", r15, 16'h0000);
    check("rst_r14", r14, 16'h0000);
    check("rst_r13", r13, 16'h0000);
    check_pc("rst_pc", 10'd0);
    rst = 1'b1;

    // Straight-line trace through the vector table
    for (int i = 0; i < NV; i++) begin
      we = vt[i].we;
      sbq.push_back('{vt[i].r15, vt[i].r14, vt[i].r13, 10'(i + 1)});
      edge1();
      e = sbq.pop_front();
      check($sformatf("v%0d_r15", i), r15, e.r15);
      check($sformatf("v%0d_r14", i), r14, e.r14);
      check($sformatf("v%0d_r13", i), r13, e.r13);
      check_pc($sformatf("v%0d_pc", i), e.pc);
    end
    we = 1'b1;

    // Reset mid-program, then address 0 runs on the next edge
    rst = 1'b0;
    edge1();
    check("rst2_r15", r15, 16'h0000);
    check("rst2_r14", r14, 16'h0000);
    check("rst2_r13", r13, 16'h0000);
    check_pc("rst2_pc", 10'd0);
    rst = 1'b1;
    edge1();
    check_pc("rel_pc", 10'd1);
    check("rel_r15", r15, 16'h0005);

    // Countdown loop, JAL over one word, HALT, spin loop
    clear_rom();
    dut.Instructions.ram[0] = 16'h8F0A;
    dut.Instructions.ram[1] = 16'h8FFF;
    dut.Instructions.ram[2] = 16'hDF0F;
    dut.Instructions.ram[3] = 16'hEE02;
    dut.Instructions.ram[4] = 16'h8D01;
    dut.Instructions.ram[5] = 16'hF000;
    dut.Instructions.ram[6] = 16'h8D07;
    dut.Instructions.ram[7] = 16'hC000;
    rst = 1'b0;
    edge1();
    rst = 1'b1;
    c = 0;
    while (dut.pc_q != 10'd5 && c < 100) begin
      edge1();
      c++;
    end
    check_pc("loop_exit_pc", 10'd5);
    check("loop_cycles", 16'(c), 16'd22);
    check("loop_r15", r15, 16'h0000);
    check("jal_r14", r14, 16'h0004);
    check("jal_skip_r13", r13, 16'h0000);
    for (int i = 0; i < 5; i++) edge1();
`ifdef RV16R_HALT_EN
    check_pc("halt_pc", 10'd5);
    check("halt_r13", r13, 16'h0000);
`else
    check_pc("spin_pc", 10'd7);
    check("nop_r13", r13, 16'h0007);
`endif
    check("after_r14", r14, 16'h0004);

    // Reset overrides HALT / spin
    rst = 1'b0;
    edge1();
    check_pc("rst3_pc", 10'd0);
    check("rst3_r14", r14, 16'h0000);
    rst = 1'b1;
    edge1();
    check_pc("rst3_rel_pc", 10'd1);
    check("rst3_rel_r15", r15, 16'h000A);

    // Backward JAL to 1023 with rd=R0, then wrap to 0
    clear_rom();
    dut.Instructions.ram[0]    = 16'hE0FF;
    dut.Instructions.ram[1023] = 16'h8D01;
    rst = 1'b0;
    edge1();
    rst = 1'b1;
    edge1();
    check_pc("jal_back_pc", 10'd1023);
    check("jal_r0_r13", r13, 16'h0000);
    edge1();
    check_pc("wrap_pc", 10'd0);
    check("wrap_r13", r13, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
